// File: rtl/rf_port_arbiter.sv
// rtl/rf_port_arbiter.sv - Round-robin arbiter sequencing two requesters onto a shared register file
module rf_port_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              ack_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              ack_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              busy,
    output logic              rf_mode,
    output logic [ADDR_W-1:0] rf_write_address,
    output logic [DATA_W-1:0] rf_write_value,
    output logic [ADDR_W-1:0] rf_read_address,
    input  logic [DATA_W-1:0] rf_read_value
);
    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, EXEC = 2'd2} state_t;

    state_t            state, stateNext;
    logic              ptrB, ptrBNext;
    logic              grantB, grantBNext;
    logic              opWe, opWeNext;
    logic [ADDR_W-1:0] opAddr, opAddrNext;
    logic [DATA_W-1:0] opWdata, opWdataNext;
    logic              modeNext, ackANext, ackBNext, busyNext;
    logic [ADDR_W-1:0] wAddrNext, rAddrNext;
    logic [DATA_W-1:0] wValueNext, rdataANext, rdataBNext;
    logic              eligA, eligB, pickB;

    // A requester whose ack is showing this cycle sits out, which hands a back-to-back slot to the other side.
    assign eligA = req_a && !ack_a;
    assign eligB = req_b && !ack_b;
    assign pickB = eligB && (!eligA || ptrB);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (eligA || eligB) stateNext = SETUP;
            SETUP:   stateNext = EXEC;
            EXEC:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        ptrBNext    = ptrB;
        grantBNext  = grantB;
        opWeNext    = opWe;
        opAddrNext  = opAddr;
        opWdataNext = opWdata;
        modeNext    = 1'b0;
        ackANext    = 1'b0;
        ackBNext    = 1'b0;
        wAddrNext   = rf_write_address;
        wValueNext  = rf_write_value;
        rAddrNext   = rf_read_address;
        rdataANext  = rdata_a;
        rdataBNext  = rdata_b;
        case (state)
            IDLE: begin
                if (eligA || eligB) begin
                    grantBNext  = pickB;
                    opWeNext    = pickB ? we_b : we_a;
                    opAddrNext  = pickB ? addr_b : addr_a;
                    opWdataNext = pickB ? wdata_b : wdata_a;
                    if (opWeNext) begin
                        wAddrNext  = opAddrNext;
                        wValueNext = opWdataNext;
                    end else begin
                        rAddrNext = opAddrNext;
                    end
                end
            end
            SETUP: modeNext = opWe;
            EXEC: begin
                ackANext = !grantB;
                ackBNext = grantB;
                ptrBNext = !grantB;
                if (!opWe) begin
                    if (grantB) rdataBNext = rf_read_value;
                    else        rdataANext = rf_read_value;
                end
            end
            default: ;
        endcase
        busyNext = (stateNext != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptrB             <= 1'b0;
            grantB           <= 1'b0;
            opWe             <= 1'b0;
            opAddr           <= '0;
            opWdata          <= '0;
            rf_mode          <= 1'b0;
            ack_a            <= 1'b0;
            ack_b            <= 1'b0;
            busy             <= 1'b0;
            rf_write_address <= '0;
            rf_write_value   <= '0;
            rf_read_address  <= '0;
            rdata_a          <= '0;
            rdata_b          <= '0;
        end else begin
            ptrB             <= ptrBNext;
            grantB           <= grantBNext;
            opWe             <= opWeNext;
            opAddr           <= opAddrNext;
            opWdata          <= opWdataNext;
            rf_mode          <= modeNext;
            ack_a            <= ackANext;
            ack_b            <= ackBNext;
            busy             <= busyNext;
            rf_write_address <= wAddrNext;
            rf_write_value   <= wValueNext;
            rf_read_address  <= rAddrNext;
            rdata_a          <= rdataANext;
            rdata_b          <= rdataBNext;
        end
    end
endmodule

// File: tb/tb_rf_port_arbiter.sv
// tb/tb_rf_port_arbiter.sv - Self-checking bench for rf_port_arbiter with a transaction-level model
module tb_rf_port_arbiter;
    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } op_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_a = 0, we_a = 0, req_b = 0, we_b = 0;
    logic [4:0]  addr_a = 0, addr_b = 0;
    logic [31:0] wdata_a = 0, wdata_b = 0;
    logic        ack_a, ack_b, busy, rf_mode;
    logic [31:0] rdata_a, rdata_b, rf_write_value, rf_read_value;
    logic [4:0]  rf_write_address, rf_read_address;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    op_t qa[$];
    op_t qb[$];
    bit  ackLog[$];

    rf_port_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a), .ack_a(ack_a), .rdata_a(rdata_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b), .ack_b(ack_b), .rdata_b(rdata_b),
        .busy(busy), .rf_mode(rf_mode),
        .rf_write_address(rf_write_address), .rf_write_value(rf_write_value),
        .rf_read_address(rf_read_address), .rf_read_value(rf_read_value)
    );

    always #5 clk = ~clk;

    // Register file stand-in: written on the clock edge while mode is high, read combinationally.
    logic [31:0] rfMem [0:31];
    bit memClr = 1'b1;
    always @(posedge clk) begin
        if (memClr) begin
            for (int i = 0; i < 32; i++) rfMem[i] <= 32'd0;
            memClr <= 1'b0;
        end else if (rf_mode) begin
            rfMem[rf_write_address] <= rf_write_value;
        end
    end
    assign rf_read_value = rfMem[rf_read_address];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Transaction model: a grant at cycle g occupies g+1 (setup) and g+2 (exec), acks at g+3.
    logic        mBusy, mMode, mAckA, mAckB, mPtrB;
    logic [31:0] mRdA, mRdB;
    logic [31:0] mMem [0:31];
    logic        actValid, actB, actWe;
    logic [4:0]  actAddr;
    logic [31:0] actData;
    int          actG;

    initial begin
        logic nAckA, nAckB, nMode, nBusy, eA, eB;
        for (int i = 0; i < 32; i++) mMem[i] = 32'd0;
        actValid = 0; actB = 0; actWe = 0; actAddr = 0; actData = 0; actG = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                mBusy = 0; mMode = 0; mAckA = 0; mAckB = 0; mPtrB = 0;
                mRdA = 0; mRdB = 0; actValid = 0;
            end
            chk("busy", 32'(busy), 32'(mBusy));
            chk("rf_mode", 32'(rf_mode), 32'(mMode));
            chk("ack_a", 32'(ack_a), 32'(mAckA));
            chk("ack_b", 32'(ack_b), 32'(mAckB));
            chk("rdata_a", rdata_a, mRdA);
            chk("rdata_b", rdata_b, mRdB);
            if (mMode) begin
                chk("rf_write_address", 32'(rf_write_address), 32'(actAddr));
                chk("rf_write_value", rf_write_value, actData);
            end
            if (actValid && !actWe && (cyc - actG) == 2)
                chk("rf_read_address", 32'(rf_read_address), 32'(actAddr));
            if (ack_a) ackLog.push_back(1'b0);
            if (ack_b) ackLog.push_back(1'b1);
            if (reset) begin
                nAckA = 0; nAckB = 0; nMode = 0; nBusy = 0;
                if (actValid) begin
                    nBusy = (cyc - actG) < 2;
                    if ((cyc - actG) == 1) nMode = actWe;
                    if ((cyc - actG) == 2) begin
                        if (actWe)     mMem[actAddr] = actData;
                        else if (actB) mRdB = mMem[actAddr];
                        else           mRdA = mMem[actAddr];
                        if (actB) nAckB = 1; else nAckA = 1;
                        mPtrB = !actB;
                        actValid = 0;
                    end
                end else begin
                    eA = req_a && !mAckA;
                    eB = req_b && !mAckB;
                    if (eA || eB) begin
                        actB    = eB && (!eA || mPtrB);
                        actWe   = actB ? we_b : we_a;
                        actAddr = actB ? addr_b : addr_a;
                        actData = actB ? wdata_b : wdata_a;
                        actG    = cyc;
                        actValid = 1;
                        nBusy   = 1;
                    end
                end
                mAckA = nAckA; mAckB = nAckB; mMode = nMode; mBusy = nBusy;
            end
            cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic op_t mk(input logic we, input logic [4:0] a, input logic [31:0] d);
        op_t o;
        o.we = we; o.addr = a; o.data = d;
        return o;
    endfunction

    function automatic logic [31:0] packLog();
        logic [31:0] v = 32'd0;
        foreach (ackLog[i]) if (i < 32) v[i] = ackLog[i];
        return v;
    endfunction

    task automatic waitAck(input bit b);
        int n = 0;
        @(negedge clk);
        while (!(b ? ack_b : ack_a) && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk(b ? "ack_b_wait" : "ack_a_wait", 32'(b ? ack_b : ack_a), 32'd1);
    endtask

    // Holds req through the ack cycle, then presents the next op (or drops req) on the following cycle.
    task automatic agent(input bit b);
        op_t op;
        while ((b ? qb.size() : qa.size()) > 0) begin
            if (b) begin
                op = qb.pop_front();
                we_b = op.we; addr_b = op.addr; wdata_b = op.data; req_b = 1;
            end else begin
                op = qa.pop_front();
                we_a = op.we; addr_a = op.addr; wdata_a = op.data; req_a = 1;
            end
            waitAck(b);
            step();
        end
        if (b) req_b = 0; else req_a = 0;
    endtask

    task automatic runOps();
        fork
            agent(1'b0);
            agent(1'b1);
        join
    endtask

    initial begin
        #2 reset = 0;
        repeat (3) step();
        reset = 1;

        // Single write then read on A
        step();
        req_a = 1; we_a = 1; addr_a = 5'd1; wdata_a = 32'd12;
        @(negedge clk); chk("t1_busy_n", 32'(busy), 32'd0);
        step(); @(negedge clk);
        chk("t1_busy_n1", 32'(busy), 32'd1);
        chk("t1_mode_n1", 32'(rf_mode), 32'd0);
        chk("t1_waddr_n1", 32'(rf_write_address), 32'd1);
        step(); @(negedge clk);
        chk("t1_mode_n2", 32'(rf_mode), 32'd1);
        chk("t1_wval_n2", rf_write_value, 32'd12);
        step(); @(negedge clk);
        chk("t1_ack_n3", 32'(ack_a), 32'd1);
        chk("t1_mode_n3", 32'(rf_mode), 32'd0);
        step();
        we_a = 0;
        step(); @(negedge clk);
        step(); @(negedge clk);
        chk("t1_raddr_m2", 32'(rf_read_address), 32'd1);
        step(); @(negedge clk);
        chk("t1_rack_m3", 32'(ack_a), 32'd1);
        chk("t1_rdata_a", rdata_a, 32'd12);
        step(); req_a = 0;

        // Contention straight after reset: A first, B three cycles later
        reset = 0; step(); step(); reset = 1;
        step();
        req_a = 1; we_a = 1; addr_a = 5'd2; wdata_a = 32'd24;
        req_b = 1; we_b = 1; addr_b = 5'd3; wdata_b = 32'd36;
        repeat (3) step();
        @(negedge clk);
        chk("t2_ack_a_n3", 32'(ack_a), 32'd1);
        chk("t2_ack_b_n3", 32'(ack_b), 32'd0);
        step(); req_a = 0;
        repeat (2) step();
        @(negedge clk);
        chk("t2_ack_b_n6", 32'(ack_b), 32'd1);
        step(); req_b = 0;
        step();
        ackLog.delete();
        qa.push_back(mk(0, 5'd2, 0)); qb.push_back(mk(0, 5'd3, 0));
        runOps();
        chk("t2_rdata_a", rdata_a, 32'd24);
        chk("t2_rdata_b", rdata_b, 32'd36);
        chk("t2_order", packLog(), 32'b10);

        // Round-robin fairness under continuous requests
        step();
        ackLog.delete();
        qa.push_back(mk(0, 5'd1, 0)); qa.push_back(mk(0, 5'd2, 0)); qa.push_back(mk(0, 5'd3, 0));
        qb.push_back(mk(0, 5'd3, 0)); qb.push_back(mk(0, 5'd2, 0)); qb.push_back(mk(0, 5'd1, 0));
        runOps();
        chk("t3_order_len", 32'(ackLog.size()), 32'd6);
        chk("t3_order", packLog(), 32'b101010);
        chk("t3_rdata_a", rdata_a, 32'd36);
        chk("t3_rdata_b", rdata_b, 32'd12);

        // Read-after-write to the same address across requesters
        step();
        ackLog.delete();
        qa.push_back(mk(1, 5'd5, 32'hDEADBEEF)); qb.push_back(mk(0, 5'd5, 0));
        runOps();
        chk("t4_rdata_b", rdata_b, 32'hDEADBEEF);
        chk("t4_model_rdata_b", mRdB, 32'hDEADBEEF);
        chk("t4_order", packLog(), 32'b10);

        // Field change during setup is ignored
        step();
        req_a = 1; we_a = 1; addr_a = 5'd4; wdata_a = 32'd7;
        step(); addr_a = 5'd9; wdata_a = 32'd99;
        @(negedge clk); chk("t5_waddr_setup", 32'(rf_write_address), 32'd4);
        step(); @(negedge clk);
        chk("t5_waddr_exec", 32'(rf_write_address), 32'd4);
        chk("t5_wval_exec", rf_write_value, 32'd7);
        step(); @(negedge clk); chk("t5_ack", 32'(ack_a), 32'd1);
        step(); req_a = 0;
        step();
        qa.push_back(mk(0, 5'd4, 0)); runOps();
        chk("t5_rd4", rdata_a, 32'd7);
        qa.push_back(mk(0, 5'd9, 0)); runOps();
        chk("t5_rd9", rdata_a, 32'd0);

        // Reset during the exec cycle of a write
        step();
        req_a = 1; we_a = 1; addr_a = 5'd6; wdata_a = 32'h55;
        step(); step();
        #1 reset = 0;
        #1;
        chk("t6_mode_async", 32'(rf_mode), 32'd0);
        chk("t6_busy_async", 32'(busy), 32'd0);
        chk("t6_ack_async", 32'(ack_a), 32'd0);
        req_a = 0;
        step(); step();
        reset = 1;
        step();
        ackLog.delete();
        qa.push_back(mk(0, 5'd7, 0)); qb.push_back(mk(0, 5'd6, 0));
        runOps();
        chk("t6_order", packLog(), 32'b10);
        chk("t6_rd6", rdata_b, 32'd0);

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
